shamt_shift_unit: RTL and testbench

SHAMT_SHIFT_UNIT -- requirements
Module: shamt_shift_unit

---
 rtl/shamt_pkg.sv | 39 +++
 rtl/shift_step.sv | 37 +++
 rtl/shamt_shift_unit.sv | 143 ++++++++++++++
 tb/tb_shamt_shift_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shamt_pkg.sv
// Shared definitions for the iterative shift unit: operation codes, FSM state
// encoding and a constant-evaluable log2 helper.
// Optional feature macro: SHAMT_ROTATE_EN (op 2'b11 becomes a legal rotate-right).
package shamt_pkg;

    // Shift kinds carried on op_i.
    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    // Controller states; kept as plain constants so the encoding is visible
    // to tools and scripts that predate enum support.
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    // Ceiling log2, usable in parameter expressions.
    function automatic int log2_f(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Whether an operation code is implemented in this build.
    function automatic logic op_is_legal(input logic [1:0] op);
`ifdef SHAMT_ROTATE_EN
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) || (op == OP_ROTR);
`else
        return (op != OP_ROTR);
`endif
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves the working value by 0..STEP bit
// positions for every supported shift kind. The rotate path only exists when
// SHAMT_ROTATE_EN is defined.
module shift_step
    import shamt_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STEP   = 1,
    parameter int AMT_W  = 5
) (
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [AMT_W-1:0]  amt_i,
    output logic [DATA_W-1:0] data_o
);

    // Select one of the STEP+1 fixed shifts; amount 0 passes the data through.
    always_comb begin
        // NOTE: assigning a default before any branch keeps this purely
        // combinational; a path that left data_o unassigned would infer a latch.
        data_o = data_i;
        for (int k = 1; k <= STEP; k++) begin
            if (amt_i == AMT_W'(k)) begin
                case (op_i)
                    OP_SLL:  data_o = data_i << k;
                    OP_SRL:  data_o = data_i >> k;
                    OP_SRA:  data_o = DATA_W'($signed(data_i) >>> k);
`ifdef SHAMT_ROTATE_EN
                    OP_ROTR: data_o = (data_i >> k) | (data_i << (DATA_W - k));
`endif
                    default: data_o = data_i;
                endcase
            end
        end
    end

endmodule

// File: rtl/shamt_shift_unit.sv
// Multi-cycle shift unit. An accepted request latches operand, operation and
// amount, then shifts by up to STEP bits per clock until the amount is used up.
// result_o only changes when a request completes. Reset is asynchronous and
// active-low on the port named reset.
// Optional feature macro: SHAMT_ROTATE_EN (enables op 2'b11 = rotate right;
// without it op 2'b11 completes immediately with err_o set).
module shamt_shift_unit
    import shamt_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int STEP    = 1,
    localparam int SHAMT_W = log2_f(DATA_W)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic [1:0]         op_i,
    input  logic               var_i,
    input  logic [DATA_W-1:0]  data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [DATA_W-1:0]  rs_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [DATA_W-1:0]  result_o,
    output logic               err_o
);

    localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

    logic [1:0]         state_q,  state_d;
    logic [SHAMT_W-1:0] cnt_q,    cnt_d;
    logic [DATA_W-1:0]  work_q,   work_d;
    logic [1:0]         op_q,     op_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               err_q,    err_d;

    logic [SHAMT_W-1:0] amt_sel;
    logic [SHAMT_W-1:0] step_amt;
    logic [DATA_W-1:0]  step_out;

    // Only the low bits of the register source carry a shift amount.
    logic unused_rs_hi;
    assign unused_rs_hi = ^rs_i[DATA_W-1:SHAMT_W];

    // Amount source: immediate or low bits of the register operand.
    always_comb begin
        amt_sel = var_i ? rs_i[SHAMT_W-1:0] : shamt_i;
    end

    // Bits moved this cycle: the whole remainder if it fits, else a full step.
    always_comb begin
        step_amt = (cnt_q > STEP_AMT) ? STEP_AMT : cnt_q;
    end

    shift_step #(
        .DATA_W (DATA_W),
        .STEP   (STEP),
        .AMT_W  (SHAMT_W)
    ) u_shift_step (
        .op_i   (op_q),
        .data_i (work_q),
        .amt_i  (step_amt),
        .data_o (step_out)
    );

    // Controller next-state, counter and datapath updates.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        op_d     = op_q;
        result_d = result_q;
        err_d    = err_q;

        case (state_q)
            ST_SHIFT: begin
                // Requests arriving mid-operation are dropped on purpose.
                work_d = step_out;
                cnt_d  = cnt_q - step_amt;
                if (cnt_d == '0) begin
                    state_d  = ST_DONE;
                    result_d = step_out;
                    err_d    = 1'b0;
                end
            end

            // IDLE and DONE both accept a new request; DONE otherwise falls
            // back to IDLE so done_o is a single-cycle pulse.
            default: begin
                state_d = ST_IDLE;
                if (start_i) begin
                    op_d   = op_i;
                    work_d = data_i;
                    cnt_d  = amt_sel;
                    if (!op_is_legal(op_i)) begin
                        state_d  = ST_DONE;
                        cnt_d    = '0;
                        result_d = data_i;
                        err_d    = 1'b1;
                    end else if (amt_sel == '0) begin
                        state_d  = ST_DONE;
                        result_d = data_i;
                        err_d    = 1'b0;
                    end else begin
                        state_d  = ST_SHIFT;
                    end
                end
            end
        endcase
    end

    // State registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: every register here is a plain flop (no memory array), so all of
        // them take a defined reset value, including the datapath ones.
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            work_q   <= '0;
            op_q     <= OP_SLL;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the values from
            // before this edge, independent of statement order.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            op_q     <= op_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // Status outputs decode directly from the state register.
    always_comb begin
        busy_o   = (state_q == ST_SHIFT);
        done_o   = (state_q == ST_DONE);
        result_o = result_q;
        err_o    = err_q;
    end

endmodule

// File: tb/tb_shamt_shift_unit.sv
// Scoreboard bench: two units (STEP=1 and STEP=4) share one stimulus stream.
// Each issued request pushes its hand-computed result, error flag and latency
// into a per-unit queue; a monitor pops on every done_o and compares.
module tb_shamt_shift_unit;
    import shamt_pkg::*;

    localparam int DW = 32;
    localparam int SW = 5;

    typedef struct {
        logic [1:0]    op;
        logic          use_rs;
        logic [DW-1:0] data;
        logic [SW-1:0] shamt;
        logic [DW-1:0] rs;
        logic [DW-1:0] exp_res;
        logic          exp_err;
    } vec_t;

    typedef struct {
        logic [DW-1:0] res;
        logic          err;
        int            lat;
        int            acc;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          start_i;
    logic [1:0]    op_i;
    logic          var_i;
    logic [DW-1:0] data_i;
    logic [SW-1:0] shamt_i;
    logic [DW-1:0] rs_i;

    logic          busy_w [2];
    logic          done_w [2];
    logic [DW-1:0] res_w  [2];
    logic          err_w  [2];

    exp_t          q [2][$];
    logic [DW-1:0] last_res [2];
    int            steps [2] = '{1, 4};
    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    logic          mon_en = 1'b0;

    shamt_shift_unit #(.DATA_W(DW), .STEP(1)) dut1 (
        .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i), .var_i(var_i),
        .data_i(data_i), .shamt_i(shamt_i), .rs_i(rs_i),
        .busy_o(busy_w[0]), .done_o(done_w[0]), .result_o(res_w[0]), .err_o(err_w[0])
    );

    shamt_shift_unit #(.DATA_W(DW), .STEP(4)) dut4 (
        .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i), .var_i(var_i),
        .data_i(data_i), .shamt_i(shamt_i), .rs_i(rs_i),
        .busy_o(busy_w[1]), .done_o(done_w[1]), .result_o(res_w[1]), .err_o(err_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare on every completion, otherwise result_o must hold.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                if (done_w[d] === 1'b1) begin
                    if (q[d].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_done dut%0d: got done_o=1, want no completion (cycle %0d)", d, cyc);
                    end else begin
                        exp_t e;
                        e = q[d].pop_front();
                        check($sformatf("result dut%0d", d), res_w[d], e.res);
                        check($sformatf("err dut%0d", d), {31'b0, err_w[d]}, {31'b0, e.err});
                        check($sformatf("latency dut%0d", d), DW'(cyc - e.acc), DW'(e.lat));
                        last_res[d] = e.res;
                    end
                end else begin
                    check($sformatf("hold dut%0d", d), res_w[d], last_res[d]);
                end
            end
        end
    end

    // Drive one request (caller is at a negedge) and push expectations.
    task automatic drive(input vec_t v, input logic only_dut4);
        logic [DW-1:0] rs_v;
        int            amt;
        rs_v = v.rs;
        amt  = v.use_rs ? int'(rs_v[SW-1:0]) : int'(v.shamt);
        start_i = 1'b1;
        op_i    = v.op;
        var_i   = v.use_rs;
        data_i  = v.data;
        shamt_i = v.shamt;
        rs_i    = v.rs;
        for (int d = 0; d < 2; d++) begin
            exp_t e;
            e.res = v.exp_res;
            e.err = v.exp_err;
            e.acc = cyc;
            e.lat = (amt == 0 || v.exp_err) ? 1 : (amt + steps[d] - 1) / steps[d] + 1;
            if (d == 1 || !only_dut4) q[d].push_back(e);
        end
    endtask

    // Wait until both scoreboards drain, with a cycle budget.
    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((q[0].size() != 0 || q[1].size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (q[0].size() != 0 || q[1].size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout %s: got %0d/%0d pending, want 0/0", name, q[0].size(), q[1].size());
            q[0].delete();
            q[1].delete();
        end
    endtask

    task automatic run(input vec_t v, input string name);
        drive(v, 1'b0);
        @(negedge clk);
        start_i = 1'b0;
        wait_idle(name);
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic use_rs, input logic [DW-1:0] data,
                                input logic [SW-1:0] shamt, input logic [DW-1:0] rs,
                                input logic [DW-1:0] exp_res, input logic exp_err);
        vec_t v;
        v.op = op; v.use_rs = use_rs; v.data = data; v.shamt = shamt; v.rs = rs;
        v.exp_res = exp_res; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic check_reset_outputs(input string name);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s busy dut%0d", name, d), {31'b0, busy_w[d]}, '0);
            check($sformatf("%s done dut%0d", name, d), {31'b0, done_w[d]}, '0);
            check($sformatf("%s err dut%0d", name, d), {31'b0, err_w[d]}, '0);
            check($sformatf("%s result dut%0d", name, d), res_w[d], '0);
        end
    endtask

    initial begin
        vec_t vecs[$];
        vec_t v;

        reset = 1'b0; start_i = 1'b0; op_i = OP_SLL; var_i = 1'b0;
        data_i = '0; shamt_i = '0; rs_i = '0;
        last_res[0] = '0; last_res[1] = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        vecs.push_back(mk(OP_SRA, 1'b0, 32'h8000_0000, 5'd4,  32'h0,         32'hF800_0000, 1'b0));
        vecs.push_back(mk(OP_SLL, 1'b1, 32'h0000_0001, 5'd0,  32'hFFFF_FFE7, 32'h0000_0080, 1'b0));
        vecs.push_back(mk(OP_SRL, 1'b0, 32'h1234_5678, 5'd0,  32'h0,         32'h1234_5678, 1'b0));
`ifdef SHAMT_ROTATE_EN
        vecs.push_back(mk(OP_ROTR, 1'b0, 32'h0000_000F, 5'd4, 32'h0,         32'hF000_0000, 1'b0));
        vecs.push_back(mk(OP_ROTR, 1'b0, 32'h0000_0001, 5'd1, 32'h0,         32'h8000_0000, 1'b0));
`else
        vecs.push_back(mk(OP_ROTR, 1'b0, 32'h0000_000F, 5'd4, 32'h0,         32'h0000_000F, 1'b1));
`endif
        vecs.push_back(mk(OP_SRA, 1'b0, 32'h7FFF_FFFF, 5'd31, 32'h0,         32'h0000_0000, 1'b0));
        vecs.push_back(mk(OP_SRA, 1'b1, 32'h8000_0001, 5'd0,  32'h0000_001F, 32'hFFFF_FFFF, 1'b0));
        vecs.push_back(mk(OP_SLL, 1'b0, 32'hFFFF_FFFF, 5'd31, 32'h0,         32'h8000_0000, 1'b0));
        vecs.push_back(mk(OP_SRL, 1'b0, 32'hA5A5_A5A5, 5'd5,  32'h0,         32'h052D_2D2D, 1'b0));
        vecs.push_back(mk(OP_SRA, 1'b0, 32'hC000_0000, 5'd1,  32'h0,         32'hE000_0000, 1'b0));
        vecs.push_back(mk(OP_SLL, 1'b0, 32'h0000_0003, 5'd30, 32'h0,         32'hC000_0000, 1'b0));
        vecs.push_back(mk(OP_SRL, 1'b0, 32'h8000_0000, 5'd3,  32'h0000_001F, 32'h1000_0000, 1'b0));

        foreach (vecs[i]) run(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back: start held while the first request sits in DONE.
        drive(mk(OP_SRL, 1'b0, 32'h1234_5678, 5'd0, 32'h0, 32'h1234_5678, 1'b0), 1'b0);
        @(negedge clk);
        drive(mk(OP_SLL, 1'b0, 32'h0000_0001, 5'd3, 32'h0, 32'h0000_0008, 1'b0), 1'b0);
        @(negedge clk);
        start_i = 1'b0;
        wait_idle("back_to_back");

        // Start pulsed while busy with different operands must be ignored.
        drive(mk(OP_SRL, 1'b0, 32'hF000_0000, 5'd8, 32'h0, 32'h00F0_0000, 1'b0), 1'b0);
        @(negedge clk);
        check("busy_during_shift dut0", {31'b0, busy_w[0]}, 32'd1);
        check("busy_during_shift dut1", {31'b0, busy_w[1]}, 32'd1);
        start_i = 1'b1; op_i = OP_SLL; data_i = 32'h1234_5678; shamt_i = 5'd1;
        @(negedge clk);
        start_i = 1'b0; data_i = 32'hDEAD_BEEF;
        wait_idle("ignore_busy_start");

        // Reset mid-operation: the STEP=1 unit must drop its long shift.
        drive(mk(OP_SRL, 1'b0, 32'h8000_0000, 5'd20, 32'h0, 32'h0000_0800, 1'b0), 1'b1);
        @(negedge clk);
        start_i = 1'b0;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        last_res[0] = '0;
        last_res[1] = '0;
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        check("reset_pending dut0", DW'(q[0].size()), '0);
        check("reset_pending dut1", DW'(q[1].size()), '0);

        // Unit still works after the reset.
        run(mk(OP_SRA, 1'b0, 32'h8000_0000, 5'd4, 32'h0, 32'hF800_0000, 1'b0), "post_reset");

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, want completion within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
